// File: rtl/flit_absorb_if.sv
// Flit stream and dual-FIFO write bundle for flit_absorb.
// The slave modport is the absorber's view; master is the upstream/FIFO side.
interface flit_absorb_if;
    logic        Valid_i;
    logic [31:0] Data_i;
    logic        Ready_o;
    logic        FifoAWrite_o;
    logic [31:0] FifoAData_o;
    logic        FifoAFull_i;
    logic        FifoBWrite_o;
    logic [31:0] FifoBData_o;
    logic        FifoBFull_i;
    logic        Busy_o;
    logic        Err_o;
    logic [1:0]  ErrCode_o;

    modport slave (
        input  Valid_i, Data_i, FifoAFull_i, FifoBFull_i,
        output Ready_o, FifoAWrite_o, FifoAData_o, FifoBWrite_o, FifoBData_o,
               Busy_o, Err_o, ErrCode_o
    );

    modport master (
        output Valid_i, Data_i, FifoAFull_i, FifoBFull_i,
        input  Ready_o, FifoAWrite_o, FifoAData_o, FifoBWrite_o, FifoBData_o,
               Busy_o, Err_o, ErrCode_o
    );
endinterface

// File: rtl/flit_absorb.sv
// Steers whole flit packets into FIFO A or B by the head's port bit, flagging protocol errors.
// Optional saturating error counter output ErrCnt_o under `define FLIT_ABSORB_ERR_CNT_EN.
module flit_absorb #(
    parameter int MAX_LEN = 16
) (
    input  logic         clk,
    input  logic         rst,
    flit_absorb_if.slave bus,
    output logic [1:0]   state_dbg
`ifdef FLIT_ABSORB_ERR_CNT_EN
    ,
    output logic [15:0]  ErrCnt_o
`endif
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] MAX_LEN_8 = 8'(MAX_LEN);

    state_t     state;
    logic       port_reg;
    logic [7:0] len_cnt;
    logic       busy_q;
    logic       err_q;
    logic [1:0] err_code_q;

    logic       is_head;
    logic       is_tail;
    logic       sel;
    logic       sel_full;
    logic       ready;
    logic       fire;
    logic       wr_en;
    logic [7:0] len_next;
    logic       at_limit;
    logic       err_set;
    logic [1:0] err_code_next;

    assign is_head  = (bus.Data_i[31:30] == 2'b00);
    assign is_tail  = (bus.Data_i[31:30] == 2'b11);
    assign len_next = len_cnt + 8'd1;
    assign at_limit = (len_next == MAX_LEN_8);

    // Handshake: a flit transfers on Fire = Valid_i & Ready_o; Ready_o never depends on
    // the flit being taken, only on state, flit type and the selected FIFO's fullness.
    always_comb begin
        sel = port_reg;
        if (state == IDLE) sel = bus.Data_i[29];
        sel_full = sel ? bus.FifoBFull_i : bus.FifoAFull_i;
        ready = 1'b1;
        case (state)
            IDLE:    if (is_head) ready = ~sel_full;
            BUSY:    ready = ~sel_full;
            default: ready = 1'b1;
        endcase
        if (rst) ready = 1'b0;
    end

    assign fire  = bus.Valid_i & ready;
    assign wr_en = ((state == IDLE) & is_head) | (state == BUSY);

    // Overlong wins over nested head when both land on the same flit.
    always_comb begin
        err_set       = 1'b0;
        err_code_next = 2'b00;
        if (fire) begin
            if (state == IDLE && !is_head) begin
                err_set       = 1'b1;
                err_code_next = 2'b01;
            end else if (state == BUSY && !is_tail && at_limit) begin
                err_set       = 1'b1;
                err_code_next = 2'b11;
            end else if (state == BUSY && is_head) begin
                err_set       = 1'b1;
                err_code_next = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            port_reg   <= 1'b0;
            len_cnt    <= 8'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            err_q <= err_set;
            if (err_set) err_code_q <= err_code_next;
            if (fire) begin
                case (state)
                    IDLE: begin
                        if (is_head) begin
                            port_reg <= bus.Data_i[29];
                            len_cnt  <= 8'd1;
                            state    <= BUSY;
                            busy_q   <= 1'b1;
                        end
                    end
                    BUSY: begin
                        if (is_tail) begin
                            len_cnt <= 8'd0;
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (at_limit) begin
                            len_cnt <= len_next;
                            state   <= DRAIN;
                            busy_q  <= 1'b0;
                        end else begin
                            len_cnt <= len_next;
                        end
                    end
                    DRAIN: begin
                        if (is_tail) begin
                            len_cnt <= 8'd0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FLIT_ABSORB_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                ErrCnt_o <= 16'd0;
        else if (err_set && ErrCnt_o != 16'hFFFF) ErrCnt_o <= ErrCnt_o + 16'd1;
    end
`endif

    assign bus.Ready_o      = ready;
    assign bus.FifoAWrite_o = fire & wr_en & ~sel;
    assign bus.FifoBWrite_o = fire & wr_en & sel;
    assign bus.FifoAData_o  = bus.Data_i;
    assign bus.FifoBData_o  = bus.Data_i;
    assign bus.Busy_o       = busy_q;
    assign bus.Err_o        = err_q;
    assign bus.ErrCode_o    = err_code_q;
    assign state_dbg        = state;
endmodule

// File: tb/tb_flit_absorb.sv
// Directed bench for flit_absorb built with MAX_LEN=4 so the overlong path is reachable.
module tb_flit_absorb;
    logic        clk;
    logic        rst;
    logic [1:0]  state_dbg;
`ifdef FLIT_ABSORB_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Expected writes as {port, data}.
    logic [32:0] exp_q[$];

    flit_absorb_if bus ();

    flit_absorb #(.MAX_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef FLIT_ABSORB_ERR_CNT_EN
        ,
        .ErrCnt_o  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic v, input logic [31:0] d, input logic af, input logic bf);
        @(negedge clk);
        bus.Valid_i     = v;
        bus.Data_i      = d;
        bus.FifoAFull_i = af;
        bus.FifoBFull_i = bf;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h0000_0001, 1'b0, 1'b0);
        n_checks++;
        if (bus.Ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.Ready_o); end
        n_checks++;
        if ({bus.FifoAWrite_o, bus.FifoBWrite_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_writes got=%b exp=00", {bus.FifoAWrite_o, bus.FifoBWrite_o});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Busy_o, bus.Err_o, bus.ErrCode_o, state_dbg} !== 6'b000000) begin
            n_fail++; $display("FAIL reset_state busy/err/code/state got=%b exp=000000",
                               {bus.Busy_o, bus.Err_o, bus.ErrCode_o, state_dbg});
        end
        rst = 1'b0;
    endtask

    task automatic test_packet_a();
        logic [31:0] flits[4];
        logic [3:0]  exp_busy;
        logic [32:0] exp;
        flits    = '{32'h0000_0001, 32'h4000_0002, 32'hC000_0003, 32'h0};
        exp_busy = 4'b0110;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, flits[i]});
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, flits[i], 1'b0, 1'b0);
            n_checks++;
            if (bus.FifoAWrite_o !== (i < 3) || bus.FifoBWrite_o !== 1'b0) begin
                n_fail++; $display("FAIL pkt_a_write[%0d] a=%b b=%b exp a=%b b=0", i,
                                   bus.FifoAWrite_o, bus.FifoBWrite_o, i < 3);
            end
            if (bus.FifoAWrite_o === 1'b1 && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if ({1'b0, bus.FifoAData_o} !== exp) begin
                    n_fail++; $display("FAIL pkt_a_data[%0d] got=%h exp=%h", i, bus.FifoAData_o, exp[31:0]);
                end
            end
            n_checks++;
            if (bus.Busy_o !== exp_busy[3-i] || bus.Err_o !== 1'b0) begin
                n_fail++; $display("FAIL pkt_a_busy_err[%0d] busy=%b err=%b exp busy=%b err=0", i,
                                   bus.Busy_o, bus.Err_o, exp_busy[3-i]);
            end
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL pkt_a_missing left=%0d exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h2000_0010, 1'b0, 1'b1);
            n_checks++;
            if ({bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, bus.Busy_o} !== 4'b0000) begin
                n_fail++; $display("FAIL bp_stall[%0d] rdy/wa/wb/busy got=%b exp=0000", i,
                                   {bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, bus.Busy_o});
            end
        end
        drive(1'b1, 32'h2000_0010, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, bus.Busy_o} !== 4'b1010 ||
            bus.FifoBData_o !== 32'h2000_0010) begin
            n_fail++; $display("FAIL bp_release rdy/wa/wb/busy got=%b data=%h exp=1010 data=20000010",
                               {bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, bus.Busy_o}, bus.FifoBData_o);
        end
        // FIFO A full must not stall a packet locked to B.
        drive(1'b1, 32'hC000_0011, 1'b1, 1'b0);
        n_checks++;
        if ({bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, bus.Busy_o} !== 4'b1011) begin
            n_fail++; $display("FAIL bp_other_full rdy/wa/wb/busy got=%b exp=1011",
                               {bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, bus.Busy_o});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (bus.Busy_o !== 1'b0 || bus.Err_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_end busy=%b err=%b exp busy=0 err=0", bus.Busy_o, bus.Err_o);
        end
    endtask

    task automatic test_orphan();
        drive(1'b1, 32'h4000_00AA, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, bus.Err_o} !== 4'b1000) begin
            n_fail++; $display("FAIL orphan_accept rdy/wa/wb/err got=%b exp=1000",
                               {bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, bus.Err_o});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Err_o, bus.ErrCode_o, state_dbg, bus.Busy_o} !== 6'b101000) begin
            n_fail++; $display("FAIL orphan_err err/code/state/busy got=%b exp=101000",
                               {bus.Err_o, bus.ErrCode_o, state_dbg, bus.Busy_o});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (bus.Err_o !== 1'b0) begin n_fail++; $display("FAIL orphan_pulse err=%b exp=0", bus.Err_o); end
    endtask

    task automatic test_overlong();
        logic [31:0] flits[8];
        logic [1:0]  exp_state[8];
        flits     = '{32'h0000_0100, 32'h4000_0101, 32'h4000_0102, 32'h4000_0103,
                      32'h4000_0104, 32'h8000_0105, 32'hC000_0106, 32'h0};
        exp_state = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        for (int i = 0; i < 8; i++) begin
            drive(i < 7, flits[i], 1'b0, 1'b0);
            n_checks++;
            if (bus.FifoAWrite_o !== (i < 4) || bus.FifoBWrite_o !== 1'b0 || state_dbg !== exp_state[i]) begin
                n_fail++; $display("FAIL overlong[%0d] wa=%b wb=%b state=%0d exp wa=%b wb=0 state=%0d", i,
                                   bus.FifoAWrite_o, bus.FifoBWrite_o, state_dbg, i < 4, exp_state[i]);
            end
            n_checks++;
            if (bus.Err_o !== (i == 4) || (i == 4 && bus.ErrCode_o !== 2'b11)) begin
                n_fail++; $display("FAIL overlong_err[%0d] err=%b code=%b exp err=%b code=11", i,
                                   bus.Err_o, bus.ErrCode_o, i == 4);
            end
        end
    endtask

    task automatic test_nested_reset();
        logic [31:0] flits[3];
        flits = '{32'h2000_0200, 32'h2000_0201, 32'h4000_0202};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, flits[i], 1'b0, 1'b0);
            n_checks++;
            if (bus.FifoBWrite_o !== 1'b1 || bus.FifoAWrite_o !== 1'b0 || bus.FifoBData_o !== flits[i]) begin
                n_fail++; $display("FAIL nested_write[%0d] wa=%b wb=%b data=%h exp wa=0 wb=1 data=%h", i,
                                   bus.FifoAWrite_o, bus.FifoBWrite_o, bus.FifoBData_o, flits[i]);
            end
            n_checks++;
            if (bus.Err_o !== (i == 2) || (i == 2 && bus.ErrCode_o !== 2'b10)) begin
                n_fail++; $display("FAIL nested_err[%0d] err=%b code=%b exp err=%b code=10", i,
                                   bus.Err_o, bus.ErrCode_o, i == 2);
            end
        end
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 32'hC000_0203, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, state_dbg} !== 5'b10000) begin
            n_fail++; $display("FAIL post_reset_tail rdy/wa/wb/state got=%b exp=10000",
                               {bus.Ready_o, bus.FifoAWrite_o, bus.FifoBWrite_o, state_dbg});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (bus.Err_o !== 1'b1 || bus.ErrCode_o !== 2'b01) begin
            n_fail++; $display("FAIL post_reset_orphan err=%b code=%b exp err=1 code=01", bus.Err_o, bus.ErrCode_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] flits[5];
        logic [4:0]  exp_busy;
        logic [4:0]  exp_wa;
        logic [4:0]  exp_wb;
        flits    = '{32'h0000_0300, 32'hC000_0301, 32'h2000_0302, 32'hC000_0303, 32'h0};
        exp_busy = 5'b01010;
        exp_wa   = 5'b11000;
        exp_wb   = 5'b00110;
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, flits[i], 1'b0, 1'b0);
            n_checks++;
            if (bus.FifoAWrite_o !== exp_wa[4-i] || bus.FifoBWrite_o !== exp_wb[4-i] ||
                bus.Busy_o !== exp_busy[4-i] || bus.Err_o !== 1'b0) begin
                n_fail++; $display("FAIL b2b[%0d] wa=%b wb=%b busy=%b err=%b exp wa=%b wb=%b busy=%b err=0", i,
                                   bus.FifoAWrite_o, bus.FifoBWrite_o, bus.Busy_o, bus.Err_o,
                                   exp_wa[4-i], exp_wb[4-i], exp_busy[4-i]);
            end
        end
    endtask

`ifdef FLIT_ABSORB_ERR_CNT_EN
    task automatic test_err_cnt();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h4000_0400 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL err_cnt got=%0d exp=3", err_cnt); end
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL err_cnt_clear got=%0d exp=0", err_cnt); end
    endtask
`endif

    initial begin
        rst             = 1'b1;
        bus.Valid_i     = 1'b0;
        bus.Data_i      = 32'h0;
        bus.FifoAFull_i = 1'b0;
        bus.FifoBFull_i = 1'b0;
        test_reset();
        test_packet_a();
        test_backpressure();
        test_orphan();
        test_overlong();
        test_nested_reset();
        test_back_to_back();
`ifdef FLIT_ABSORB_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flit_absorb.md
Name: flit_absorb

Overview:
- Receive-side counterpart of the two-source flit emitter.
- Accepts a single 32-bit valid/ready flit stream and steers whole packets into one of two downstream FIFOs (A or B), chosen by a port bit in the head flit.
- Locks onto a port from head to tail.
- Detects protocol violations: orphan flits, nested heads, overlong packets. Drops or truncates per the rules below.

Parameters:
- MAX_LEN, 16, maximum flits per packet including head and tail. Legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- Valid_i  in  1  upstream flit valid.
- Data_i  in  32  flit. [31:30] type: 00 head, 11 tail, 01/10 body. In head flits, [29] is the port select (0=A, 1=B).
- Ready_o  out  1  upstream ready; Fire = Valid_i & Ready_o.
- FifoAWrite_o  out  1  write strobe, FIFO A.
- FifoAData_o  out  32  write data, FIFO A (= Data_i).
- FifoAFull_i  in  1  FIFO A full.
- FifoBWrite_o  out  1  write strobe, FIFO B.
- FifoBData_o  out  32  write data, FIFO B (= Data_i).
- FifoBFull_i  in  1  FIFO B full.
- Busy_o  out  1  high while a packet is locked (state BUSY).
- Err_o  out  1  one-cycle error pulse, registered.
- ErrCode_o  out  2  code for the last error, valid with Err_o: 01 orphan, 10 nested head, 11 overlong.

Behaviour:
- State machine, 2-bit: IDLE, BUSY, DRAIN.
- Registers: PortReg (1b), LenCnt (8b).
- Reset values: state=IDLE, PortReg=0, LenCnt=0, Busy_o=0, Err_o=0, ErrCode_o=00.
- While rst=1: Ready_o=0 and both write strobes are 0.
- Datapath is zero-latency. FifoXData_o = Data_i. A write strobe asserts in the same cycle as Fire.
- Sel (selected port):
  - IDLE: Sel = Data_i[29].
  - BUSY: Sel = PortReg.
- Ready_o:
  - IDLE with a head flit, or BUSY: Ready_o = ~Full of Sel.
  - IDLE with a non-head flit: Ready_o = 1.
  - DRAIN: Ready_o = 1.
- FifoAWrite_o = Fire & write-enabled & Sel==0. FifoBWrite_o likewise with Sel==1.
- IDLE:
  - Fire on head: write the flit, PortReg<=Data_i[29], LenCnt<=1, go to BUSY.
  - Fire on non-head: drop it, Err_o pulse with code 01, stay in IDLE.
- BUSY:
  - Every Fire writes to PortReg's FIFO and increments LenCnt.
  - Tail: go to IDLE, LenCnt<=0.
  - Head: written as data, Err_o pulse code 10, stay in BUSY (counted).
  - Non-tail flit with LenCnt+1==MAX_LEN: written, Err_o pulse code 11, go to DRAIN.
- DRAIN:
  - Every Fire is dropped (no write).
  - Tail: go to IDLE.
  - Any other flit type: stay in DRAIN, no further error.
- Full FIFO: Ready_o=0 and no state change. The other FIFO's fullness is irrelevant in BUSY.
- Valid_i low: nothing changes.
- Err_o is registered: it asserts in the cycle after the offending Fire.
- Reset mid-packet: returns to IDLE immediately. Following body/tail flits are treated as orphans (code 01).
- Back-to-back packets: a head may be accepted in the cycle after the tail. No bubble is required.

Optional Feature:
- Macro: FLIT_ABSORB_ERR_CNT_EN.
- Defined: adds output ErrCnt_o [15:0]. Saturating count of Err_o pulses; cleared by rst; holds at 16'hFFFF.
- Undefined: port absent, no counter logic. All other behaviour is identical.

Test Plan:
- Packet to A: head 0x0000_0001 ([29]=0), body 0x4000_0002, tail 0xC000_0003, Valid_i held high, FIFOs not full.
  -> three consecutive FifoAWrite_o pulses carrying that data; FifoBWrite_o stays 0; Busy_o = 0,1,1,0 across cycles; no Err_o.
- Backpressure: head 0x2000_0010 ([29]=1) with FifoBFull_i=1 for 3 cycles, FifoAFull_i=0.
  -> Ready_o=0 for 3 cycles with no writes. Write occurs on the 4th cycle. Busy_o rises the cycle after.
- Orphan: body 0x4000_00AA presented in IDLE.
  -> Ready_o=1, no write, Err_o=1 with ErrCode_o=01 one cycle later, state stays IDLE.
- Overlong with MAX_LEN=4: head plus 5 body flits plus tail.
  -> 4 writes; Err_o code 11 after the 4th; remaining 2 flits dropped; back in IDLE after the tail.
- Nested head, then reset: head, head, body; then rst for 1 cycle; then tail.
  -> 3 writes to the same port; Err_o code 10. After reset the tail is dropped with code 01.
- With FLIT_ABSORB_ERR_CNT_EN: 3 orphan flits.
  -> ErrCnt_o=3. rst then clears it to 0.
